// File: rtl/multi_button_debouncer.sv
// N_CH-channel counter-based button debouncer: 2-flop synchroniser, 4-state FSM per channel, press/release ticks.
// Optional auto-repeat ticks while a button is held are enabled by defining DEBOUNCE_REPEAT_EN.
module multi_button_debouncer #(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = 500000,
    parameter int ACTIVE_LOW = 0
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int HOLD_CNT   = 50000000,
    parameter int REPEAT_CNT = 10000000
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] rise_tick,
    output logic [N_CH-1:0] fall_tick,
    output logic            any_press
`ifdef DEBOUNCE_REPEAT_EN
    ,
    output logic [N_CH-1:0] repeat_tick
`endif
);

    localparam int CNT_W = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [N_CH-1:0] SYNC_IDLE = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    typedef enum logic [1:0] {
        ST_LOW,
        ST_RISE_WAIT,
        ST_HIGH,
        ST_FALL_WAIT
    } state_t;

    state_t           r_state     [N_CH];
    state_t           w_state_nxt [N_CH];
    logic [CNT_W-1:0] r_cnt       [N_CH];
    logic [CNT_W-1:0] w_cnt_nxt   [N_CH];
    logic [N_CH-1:0]  r_s1;
    logic [N_CH-1:0]  r_s2;
    logic [N_CH-1:0]  w_sw_s;
    logic [N_CH-1:0]  w_rise_nxt;
    logic [N_CH-1:0]  w_fall_nxt;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HOLD_MAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CNT - 1);

    logic [HOLD_W-1:0] r_hold     [N_CH];
    logic [HOLD_W-1:0] w_hold_nxt [N_CH];
    logic [N_CH-1:0]   r_rep_phase;
    logic [N_CH-1:0]   w_rep_phase_nxt;
    logic [N_CH-1:0]   w_rep_nxt;
`endif

    // Polarity is normalised after the synchroniser so every FSM sees active-high
    assign w_sw_s = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;

    always_comb begin
        db_level = '0;
        for (int i = 0; i < N_CH; i++) begin
            db_level[i] = (r_state[i] == ST_HIGH) || (r_state[i] == ST_FALL_WAIT);
        end
    end

    always_comb begin
        w_rise_nxt = '0;
        w_fall_nxt = '0;
`ifdef DEBOUNCE_REPEAT_EN
        w_rep_phase_nxt = r_rep_phase;
        w_rep_nxt       = '0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_LOW: begin
                    if (w_sw_s[i]) begin
                        w_state_nxt[i] = ST_RISE_WAIT;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_RISE_WAIT: begin
                    if (!w_sw_s[i]) begin
                        w_state_nxt[i] = ST_LOW;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i] = ST_HIGH;
                        w_rise_nxt[i]  = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!w_sw_s[i]) begin
                        w_state_nxt[i] = ST_FALL_WAIT;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_FALL_WAIT: begin
                    if (w_sw_s[i]) begin
                        w_state_nxt[i] = ST_HIGH;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i] = ST_LOW;
                        w_fall_nxt[i]  = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: w_state_nxt[i] = ST_LOW;
            endcase

`ifdef DEBOUNCE_REPEAT_EN
            // Hold schedule only advances while staying HIGH; FALL_WAIT freezes it, LOW clears it
            w_hold_nxt[i] = r_hold[i];
            if ((w_state_nxt[i] == ST_LOW) || (w_state_nxt[i] == ST_RISE_WAIT)) begin
                w_hold_nxt[i]      = '0;
                w_rep_phase_nxt[i] = 1'b0;
            end else if ((r_state[i] == ST_HIGH) && (w_state_nxt[i] == ST_HIGH)) begin
                if (r_hold[i] == (r_rep_phase[i] ? REP_LAST : HOLD_LAST)) begin
                    w_rep_nxt[i]       = 1'b1;
                    w_hold_nxt[i]      = '0;
                    w_rep_phase_nxt[i] = 1'b1;
                end else begin
                    w_hold_nxt[i] = r_hold[i] + HOLD_W'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1      <= SYNC_IDLE;
            r_s2      <= SYNC_IDLE;
            rise_tick <= '0;
            fall_tick <= '0;
            any_press <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_LOW;
                r_cnt[i]   <= '0;
            end
`ifdef DEBOUNCE_REPEAT_EN
            repeat_tick <= '0;
            r_rep_phase <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_hold[i] <= '0;
            end
`endif
        end else begin
            r_s1      <= sw;
            r_s2      <= r_s1;
            rise_tick <= w_rise_nxt;
            fall_tick <= w_fall_nxt;
            any_press <= |w_rise_nxt;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
`ifdef DEBOUNCE_REPEAT_EN
            repeat_tick <= w_rep_nxt;
            r_rep_phase <= w_rep_phase_nxt;
            for (int i = 0; i < N_CH; i++) begin
                r_hold[i] <= w_hold_nxt[i];
            end
`endif
        end
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Self-checking bench for multi_button_debouncer (2 channels, STABLE_CNT=4) against a run-length reference model.
`timescale 1ns/1ps
module tb_multi_button_debouncer;

    localparam int N_CH       = 2;
    localparam int STABLE_CNT = 4;
    localparam int HOLD_CNT   = 8;
    localparam int REPEAT_CNT = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] sw = '0;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] rise_tick;
    logic [N_CH-1:0] fall_tick;
    logic            any_press;
`ifdef DEBOUNCE_REPEAT_EN
    logic [N_CH-1:0] repeat_tick;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: two-sample delay line and, per channel, the length of the
    // current run of synchronised samples that disagree with the debounced level.
    logic [N_CH-1:0] m_s1, m_s2, m_lvl;
    int              m_run [N_CH];

    always #5 clk = ~clk;

    multi_button_debouncer #(
        .N_CH(N_CH),
        .STABLE_CNT(STABLE_CNT),
        .ACTIVE_LOW(0)
`ifdef DEBOUNCE_REPEAT_EN
        ,
        .HOLD_CNT(HOLD_CNT),
        .REPEAT_CNT(REPEAT_CNT)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .db_level(db_level),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .any_press(any_press)
`ifdef DEBOUNCE_REPEAT_EN
        ,
        .repeat_tick(repeat_tick)
`endif
    );

    task automatic model_reset();
        m_s1  = '0;
        m_s2  = '0;
        m_lvl = '0;
        for (int c = 0; c < N_CH; c++) m_run[c] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive one input value across one clock edge, advance the model, check all outputs.
    task automatic step(input logic [N_CH-1:0] v, output logic [N_CH-1:0] r_obs, output logic [N_CH-1:0] f_obs);
        logic [N_CH-1:0] samp;
        logic [N_CH-1:0] er, ef;
        sw = v;
        @(posedge clk);
        samp = m_s2;
        m_s2 = m_s1;
        m_s1 = v;
        er = '0;
        ef = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (samp[c] != m_lvl[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == STABLE_CNT + 1) begin
                if (m_lvl[c]) ef[c] = 1'b1;
                else er[c] = 1'b1;
                m_lvl[c] = ~m_lvl[c];
                m_run[c] = 0;
            end
        end
        #1;
        n_cmp += 4;
        if (db_level !== m_lvl) begin
            n_err++;
            $display("FAIL db_level @%0t: got %b expected %b", $time, db_level, m_lvl);
        end
        if (rise_tick !== er) begin
            n_err++;
            $display("FAIL rise_tick @%0t: got %b expected %b", $time, rise_tick, er);
        end
        if (fall_tick !== ef) begin
            n_err++;
            $display("FAIL fall_tick @%0t: got %b expected %b", $time, fall_tick, ef);
        end
        if (any_press !== (|er)) begin
            n_err++;
            $display("FAIL any_press @%0t: got %b expected %b", $time, any_press, |er);
        end
        r_obs = rise_tick;
        f_obs = fall_tick;
    endtask

    task automatic test_reset();
        logic [N_CH-1:0] r, f;
        sw = '1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({db_level, rise_tick, fall_tick, any_press} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got lvl=%b rise=%b fall=%b any=%b expected all 0",
                     db_level, rise_tick, fall_tick, any_press);
        end
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step('1, r, f);
            n_cmp++;
            if (r !== '0) begin
                n_err++;
                $display("FAIL reset_release_tick: got rise=%b expected 00", r);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [N_CH-1:0] r, f;
        int at = -1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(2'b01, r, f);
            if (r[0] && at < 0) at = i;
        end
        n_cmp++;
        if (at !== STABLE_CNT + 2) begin
            n_err++;
            $display("FAIL clean_press_latency: got edge %0d expected edge %0d", at, STABLE_CNT + 2);
        end
    endtask

    task automatic test_bounce();
        logic [N_CH-1:0] r, f;
        int at = -1;
        int nr = 0;
        logic [N_CH-1:0] pat [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step((i < 4) ? pat[i] : 2'b01, r, f);
            if (r[0]) begin
                nr++;
                if (at < 0) at = i;
            end
        end
        n_cmp += 2;
        if (at !== 4 + STABLE_CNT + 2) begin
            n_err++;
            $display("FAIL bounce_latency: got edge %0d expected edge %0d", at, 4 + STABLE_CNT + 2);
        end
        if (nr !== 1) begin
            n_err++;
            $display("FAIL bounce_tick_count: got %0d expected 1", nr);
        end
    endtask

    task automatic test_release();
        logic [N_CH-1:0] r, f;
        int at = -1;
        int nf = 0;
        do_reset();
        for (int i = 0; i < 8; i++) step(2'b01, r, f);
        for (int i = 0; i < 10; i++) begin
            step(2'b00, r, f);
            if (f[0] && at < 0) at = i;
        end
        n_cmp++;
        if (at !== STABLE_CNT + 2) begin
            n_err++;
            $display("FAIL release_latency: got edge %0d expected edge %0d", at, STABLE_CNT + 2);
        end
        for (int i = 0; i < 8; i++) step(2'b01, r, f);
        for (int i = 0; i < 12; i++) begin
            step((i < 2) ? 2'b00 : 2'b01, r, f);
            if (f[0]) nf++;
        end
        n_cmp += 2;
        if (nf !== 0) begin
            n_err++;
            $display("FAIL release_glitch_ticks: got %0d expected 0", nf);
        end
        if (db_level[0] !== 1'b1) begin
            n_err++;
            $display("FAIL release_glitch_level: got %b expected 1", db_level[0]);
        end
    endtask

    task automatic test_simultaneous();
        logic [N_CH-1:0] r, f;
        int at = -1;
        int nr = 0;
        logic [N_CH-1:0] first = '0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(2'b11, r, f);
            if (r != '0) begin
                nr++;
                if (at < 0) begin
                    at = i;
                    first = r;
                end
            end
        end
        n_cmp += 3;
        if (at !== STABLE_CNT + 2) begin
            n_err++;
            $display("FAIL simul_latency: got edge %0d expected edge %0d", at, STABLE_CNT + 2);
        end
        if (first !== 2'b11) begin
            n_err++;
            $display("FAIL simul_rise: got %b expected 11", first);
        end
        if (nr !== 1) begin
            n_err++;
            $display("FAIL simul_tick_cycles: got %0d expected 1", nr);
        end
    endtask

    task automatic test_reset_mid();
        logic [N_CH-1:0] r, f;
        int at = -1;
        do_reset();
        for (int i = 0; i < 8; i++) step(2'b10, r, f);
        for (int i = 0; i < 4; i++) step(2'b11, r, f);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({db_level, rise_tick, fall_tick, any_press} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got lvl=%b rise=%b fall=%b any=%b expected all 0",
                     db_level, rise_tick, fall_tick, any_press);
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(2'b11, r, f);
            if (r == 2'b11 && at < 0) at = i;
        end
        n_cmp++;
        if (at !== STABLE_CNT + 2) begin
            n_err++;
            $display("FAIL reset_mid_redebounce: got edge %0d expected edge %0d", at, STABLE_CNT + 2);
        end
    endtask

    task automatic test_random();
        logic [N_CH-1:0] r, f;
        logic [N_CH-1:0] v = '0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
            end
            if ($urandom_range(0, 199) == 0) do_reset();
            step(v, r, f);
        end
    endtask

`ifdef DEBOUNCE_REPEAT_EN
    task automatic test_repeat();
        logic [N_CH-1:0] r, f;
        logic            exp_rep;
        int              rise_at = STABLE_CNT + 2;
        int              k;
        do_reset();
        for (int i = 0; i < rise_at + 24; i++) begin
            step(2'b10, r, f);
            k = i - rise_at;
            exp_rep = (k >= HOLD_CNT) && (((k - HOLD_CNT) % REPEAT_CNT) == 0);
            n_cmp++;
            if (repeat_tick !== {exp_rep, 1'b0}) begin
                n_err++;
                $display("FAIL repeat_tick edge %0d: got %b expected %b", i, repeat_tick, {exp_rep, 1'b0});
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
`ifdef DEBOUNCE_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
